// File: rtl/char_text_renderer.sv
// char_text_renderer
// Text-mode pixel generator sitting between the VGA timing generator and the
// HDMI TMDS encoder. It keeps an 80x30 character screen buffer, fetches glyph
// rows from an external synchronous character ROM and emits 24-bit RGB with
// HS/VS/VA delayed to line up with the pixel data. Single clock domain.
//
// Ports
//   clk                  pixel clock
//   rst                  asynchronous active-low reset
//   hcount, vcount       pixel position from the timing generator
//   hs_in, vs_in, va_in  sync / video-active flags aligned with the position
//   wr_en, wr_addr,      screen-buffer write port; wr_addr = row*COLS + col,
//   wr_data              wr_data[7] = inverse video, wr_data[6:0] = code
//   rom_addr             {code[6:0], glyph_row[3:0]} to the character ROM
//   rom_data             glyph row returned by the ROM one clock later
//   red, green, blue     pixel colour
//   HS, VS, VA           sync / active flags delayed to match the pixel
//
// Optional build macro CHAR_CURSOR_EN adds cursor_col/cursor_row inputs and a
// blinking underline cursor (rows 14-15 of the cursor cell, toggling every
// 32 frames). Latency is the same with or without it.
//
// Timing: inputs sampled at edge N appear on the outputs after edge N+4.
//   N   : cell address registered
//   N+1 : character byte read from the buffer
//   N+2 : rom_addr registered
//   N+3 : ROM presents the glyph row
//   N+4 : pixel registered

module char_text_renderer #(
  parameter int unsigned COLS     = 32'd80,
  parameter int unsigned ROWS     = 32'd30,
  parameter int unsigned CHAR_W   = 32'd8,
  parameter int unsigned CHAR_H   = 32'd16,
  parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        va_in,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [7:0]  wr_data,
`ifdef CHAR_CURSOR_EN
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
`endif
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        HS,
  output logic        VS,
  output logic        VA
);

  localparam int unsigned CELLS  = COLS * ROWS;
  localparam int unsigned GRID_W = COLS * CHAR_W;
  localparam int unsigned GRID_H = ROWS * CHAR_H;

  // Screen buffer: not reset, contents survive rst.
  logic [7:0]  mem_r [CELLS];

  logic        in_grid_s;
  logic        wr_ok_s;
  logic [11:0] rd_addr_s;

  // Stage registers; the number is the pipeline stage the value belongs to.
  logic [11:0] rd_addr_r;
  logic [7:0]  char_r;
  logic [2:0]  hpix1_r, hpix2_r, hpix3_r, hpix4_r;
  logic [3:0]  grow1_r, grow2_r;
  logic        grid1_r, grid2_r, grid3_r, grid4_r;
  logic        va1_r, va2_r, va3_r, va4_r;
  logic        hs1_r, hs2_r, hs3_r, hs4_r;
  logic        vs1_r, vs2_r, vs3_r, vs4_r;
  logic        attr3_r, attr4_r;

  logic        glyph_bit_s;
  logic        cursor_on_s;
  logic [23:0] pixel_s;

  // Cell lookup for the incoming position; off-grid positions read cell 0 so the buffer index stays in range
  always_comb begin
    in_grid_s = (32'(hcount) < GRID_W) && (32'(vcount) < GRID_H);
    wr_ok_s   = (32'(wr_addr) < CELLS);
    if (in_grid_s) begin
      rd_addr_s = 12'(32'(vcount[9:4]) * COLS + 32'(hcount[10:3]));
    end else begin
      rd_addr_s = 12'd0;
    end
  end

  // Screen-buffer write port; out-of-range addresses are dropped
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Data path and side-band delay line, all cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_r <= 12'd0;
      char_r    <= 8'd0;
      rom_addr  <= 11'd0;
      hpix1_r   <= 3'd0;  hpix2_r <= 3'd0;  hpix3_r <= 3'd0;  hpix4_r <= 3'd0;
      grow1_r   <= 4'd0;  grow2_r <= 4'd0;
      grid1_r   <= 1'b0;  grid2_r <= 1'b0;  grid3_r <= 1'b0;  grid4_r <= 1'b0;
      va1_r     <= 1'b0;  va2_r   <= 1'b0;  va3_r   <= 1'b0;  va4_r   <= 1'b0;
      hs1_r     <= 1'b0;  hs2_r   <= 1'b0;  hs3_r   <= 1'b0;  hs4_r   <= 1'b0;
      vs1_r     <= 1'b0;  vs2_r   <= 1'b0;  vs3_r   <= 1'b0;  vs4_r   <= 1'b0;
      attr3_r   <= 1'b0;  attr4_r <= 1'b0;
      red       <= 8'd0;
      green     <= 8'd0;
      blue      <= 8'd0;
      HS        <= 1'b0;
      VS        <= 1'b0;
      VA        <= 1'b0;
    end else begin
      // stage 1: sample position and flags
      rd_addr_r <= rd_addr_s;
      hpix1_r   <= hcount[2:0];
      grow1_r   <= vcount[3:0];
      grid1_r   <= in_grid_s;
      va1_r     <= va_in;
      hs1_r     <= hs_in;
      vs1_r     <= vs_in;
      // stage 2: buffer read (a same-edge write is not yet visible)
      char_r    <= mem_r[rd_addr_r];
      hpix2_r   <= hpix1_r;
      grow2_r   <= grow1_r;
      grid2_r   <= grid1_r;
      va2_r     <= va1_r;
      hs2_r     <= hs1_r;
      vs2_r     <= vs1_r;
      // stage 3: glyph row address to the ROM
      rom_addr  <= {char_r[6:0], grow2_r};
      attr3_r   <= char_r[7];
      hpix3_r   <= hpix2_r;
      grid3_r   <= grid2_r;
      va3_r     <= va2_r;
      hs3_r     <= hs2_r;
      vs3_r     <= vs2_r;
      // stage 4: wait for the ROM's registered output
      attr4_r   <= attr3_r;
      hpix4_r   <= hpix3_r;
      grid4_r   <= grid3_r;
      va4_r     <= va3_r;
      hs4_r     <= hs3_r;
      vs4_r     <= vs3_r;
      // stage 5: registered pixel and sync
      {red, green, blue} <= pixel_s;
      HS        <= hs4_r;
      VS        <= vs4_r;
      VA        <= va4_r;
    end
  end

`ifdef CHAR_CURSOR_EN
  logic       vs_prev_r;
  logic [5:0] frame_cnt_r;
  logic       cur_hit_s;
  logic       cur1_r, cur2_r, cur3_r, cur4_r;

  // Cursor cell match on the bottom two glyph rows (14 and 15)
  always_comb begin
    cur_hit_s = in_grid_s
             && (hcount[10:3] == {1'b0, cursor_col})
             && (vcount[9:4]  == {1'b0, cursor_row})
             && (vcount[3:1]  == 3'b111);
  end

  // Frame counter on vs_in rising edges plus cursor-hit delay line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_prev_r   <= 1'b0;
      frame_cnt_r <= 6'd0;
      cur1_r      <= 1'b0;
      cur2_r      <= 1'b0;
      cur3_r      <= 1'b0;
      cur4_r      <= 1'b0;
    end else begin
      vs_prev_r <= vs_in;
      if (vs_in && !vs_prev_r) begin
        frame_cnt_r <= frame_cnt_r + 6'd1;
      end
      cur1_r <= cur_hit_s;
      cur2_r <= cur1_r;
      cur3_r <= cur2_r;
      cur4_r <= cur3_r;
    end
  end
`endif

  // Pixel colour from the glyph bit, attribute, blanking and grid bounds
  always_comb begin
    glyph_bit_s = rom_data[3'd7 - hpix4_r] ^ attr4_r;
`ifdef CHAR_CURSOR_EN
    cursor_on_s = cur4_r & ~frame_cnt_r[5];
`else
    cursor_on_s = 1'b0;
`endif
    if (!va4_r) begin
      pixel_s = 24'h000000;
    end else if (!grid4_r) begin
      pixel_s = BG_COLOR;
    end else if (cursor_on_s || glyph_bit_s) begin
      pixel_s = FG_COLOR;
    end else begin
      pixel_s = BG_COLOR;
    end
  end

endmodule

// File: tb/tb_char_text_renderer.sv
module tb_char_text_renderer;

  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] hcount = 11'd0;
  logic [9:0]  vcount = 10'd0;
  logic        hs_in = 1'b0, vs_in = 1'b0, va_in = 1'b0, wr_en = 1'b0;
  logic [11:0] wr_addr = 12'd0;
  logic [7:0]  wr_data = 8'd0;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data = 8'd0;
  logic [7:0]  red, green, blue;
  logic        HS, VS, VA;
`ifdef CHAR_CURSOR_EN
  logic [6:0]  cursor_col = 7'd0;
  logic [4:0]  cursor_row = 5'd31;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // character ROM model: synchronous, one clock of latency
  logic [7:0] rom [2048];

  // screen model and expectation ring indexed by input cycle
  logic [7:0]  mem_m [2400];
  logic [23:0] e_rgb [64];
  logic        e_hs [64], e_vs [64], e_va [64], e_rav [64];
  logic [10:0] e_ra [64];
  logic        vs_prev_m = 1'b0;
  int          frame_m = 0;

  char_text_renderer dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
    .hs_in(hs_in), .vs_in(vs_in), .va_in(va_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef CHAR_CURSOR_EN
    .cursor_col(cursor_col), .cursor_row(cursor_row),
`endif
    .rom_addr(rom_addr), .rom_data(rom_data),
    .red(red), .green(green), .blue(blue), .HS(HS), .VS(VS), .VA(VA)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic clear_ring();
    for (int k = 0; k < 64; k++) begin
      e_rgb[k] = 24'd0; e_hs[k] = 1'b0; e_vs[k] = 1'b0; e_va[k] = 1'b0;
      e_rav[k] = 1'b0;  e_ra[k] = 11'd0;
    end
    vs_prev_m = 1'b0;
    frame_m = 0;
  endtask

  // Apply one cycle of stimulus (called at a negedge) and record what the
  // screen rules say the outputs must show for it.
  task automatic drive(input int h, input int v, input logic hs, input logic vs,
                       input logic va, input logic we, input int wa, input logic [7:0] wd);
    logic [7:0] b;
    logic [7:0] g;
    logic       bitv;
    logic       ingrid;
    int         k;
    hcount = 11'(h); vcount = 10'(v);
    hs_in = hs; vs_in = vs; va_in = va;
    wr_en = we; wr_addr = 12'(wa); wr_data = wd;
    if (we && wa < 2400) mem_m[wa] = wd;
    if (vs && !vs_prev_m) frame_m = (frame_m + 1) % 64;
    vs_prev_m = vs;
    k = cyc & 63;
    ingrid = (h < 640) && (v < 480);
    e_hs[k] = hs; e_vs[k] = vs; e_va[k] = va;
    e_rav[k] = ingrid; e_ra[k] = 11'd0; e_rgb[k] = 24'd0;
    if (ingrid) begin
      b = mem_m[(v / 16) * 80 + h / 8];
      e_ra[k] = {b[6:0], 4'(v % 16)};
      g = rom[e_ra[k]];
      bitv = g[7 - (h % 8)] ^ b[7];
`ifdef CHAR_CURSOR_EN
      if ((h / 8 == int'(cursor_col)) && (v / 16 == int'(cursor_row)) &&
          (v % 16 >= 14) && (frame_m < 32)) bitv = 1'b1;
`endif
      if (va) e_rgb[k] = bitv ? FG : BG;
    end else if (va) begin
      e_rgb[k] = BG;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'd0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hcount = 11'($urandom_range(0, 799)); vcount = 10'($urandom_range(0, 524));
      hs_in = 1'($urandom); vs_in = 1'($urandom); va_in = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({red, green, blue, HS, VS, VA} !== 27'd0 || rom_addr !== 11'd0) begin
        failures++;
        $display("FAIL reset_hold got rgb=%h hs/vs/va=%b%b%b rom_addr=%h, required all zero",
                 {red, green, blue}, HS, VS, VA, rom_addr);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    clear_ring();
    // buffer contents are unknown yet, so stay outside the grid here
    for (int i = 0; i < 14; i++) begin
      int k;
      drive($urandom_range(640, 799), $urandom_range(0, 524), 1'($urandom), 1'($urandom),
            1'($urandom), 1'b0, 0, 8'd0);
      k = (cyc - 5) & 63;
      checks++;
      if ({red, green, blue} !== e_rgb[k] || {HS, VS, VA} !== {e_hs[k], e_vs[k], e_va[k]}) begin
        failures++;
        $display("FAIL reset_release cyc=%0d got rgb=%h sync=%b%b%b required rgb=%h sync=%b%b%b",
                 cyc, {red, green, blue}, HS, VS, VA, e_rgb[k], e_hs[k], e_vs[k], e_va[k]);
      end
    end
  endtask

  task automatic fill_buffer();
    for (int a = 0; a < 2400; a++) drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, a, 8'($urandom));
  endtask

  task automatic test_glyph_latency();
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'h41);
    drive(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'd0);
    drive(1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'd0);
    idle();
    checks++;
    if (rom_addr !== 11'h410) begin
      failures++; $display("FAIL glyph_rom_addr got=%h required=410", rom_addr);
    end
    idle(); idle();
    checks++;
    if ({red, green, blue} !== 24'hFFFFFF) begin
      failures++; $display("FAIL glyph_px0 got=%h required=ffffff", {red, green, blue});
    end
    idle();
    checks++;
    if ({red, green, blue} !== 24'h000000) begin
      failures++; $display("FAIL glyph_px1 got=%h required=000000", {red, green, blue});
    end
  endtask

  task automatic test_inverse_bounds();
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 81, 8'hC1);
    drive(8, 16, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'd0);
    drive(9, 16, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'd0);
    idle(); idle(); idle();
    checks++;
    if ({red, green, blue} !== 24'h000000) begin
      failures++; $display("FAIL inverse_px8 got=%h required=000000", {red, green, blue});
    end
    idle();
    checks++;
    if ({red, green, blue} !== 24'hFFFFFF) begin
      failures++; $display("FAIL inverse_px9 got=%h required=ffffff", {red, green, blue});
    end
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 352, 8'h11);
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2399, 8'h22);
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 8'h33);
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2400, 8'h55);
    drive(256, 64, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'd0);
    drive(632, 464, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'd0);
    drive(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'd0);
    checks++;
    if (rom_addr !== 11'h110) begin
      failures++; $display("FAIL bounds_cell352 got=%h required=110", rom_addr);
    end
    idle();
    checks++;
    if (rom_addr !== 11'h220) begin
      failures++; $display("FAIL bounds_cell2399 got=%h required=220", rom_addr);
    end
    idle();
    checks++;
    if (rom_addr !== 11'h330) begin
      failures++; $display("FAIL bounds_cell0 got=%h required=330", rom_addr);
    end
  endtask

  task automatic test_blank_grid_edge();
    int p;
    drive(9, 16, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'd0);   // would be foreground if active
    drive(640, 100, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'd0);
    drive(100, 480, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'd0);
    idle(); idle();
    checks++;
    if ({red, green, blue} !== 24'h000000) begin
      failures++; $display("FAIL blank_rgb got=%h required=000000", {red, green, blue});
    end
    idle();
    checks++;
    if ({red, green, blue} !== BG) begin
      failures++; $display("FAIL grid_right got=%h required=%h", {red, green, blue}, BG);
    end
    idle();
    checks++;
    if ({red, green, blue} !== BG) begin
      failures++; $display("FAIL grid_bottom got=%h required=%h", {red, green, blue}, BG);
    end
    p = cyc;
    drive(700, 500, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'd0);
    for (int i = 0; i < 8; i++) begin
      drive(700, 500, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'd0);
      checks++;
      if (HS !== (cyc - 5 == p)) begin
        failures++; $display("FAIL hs_delay step=%0d got=%b required=%b", i, HS, (cyc - 5 == p));
      end
    end
  endtask

  task automatic test_read_during_write();
    drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 5, 8'h07);
    drive(40, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'd0);
    drive(41, 0, 1'b0, 1'b0, 1'b1, 1'b1, 5, 8'h42);
    idle();
    checks++;
    if (rom_addr !== 11'h070) begin
      failures++; $display("FAIL rdw_old got=%h required=070", rom_addr);
    end
    idle();
    checks++;
    if (rom_addr !== 11'h420) begin
      failures++; $display("FAIL rdw_new got=%h required=420", rom_addr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int k, ka;
      drive($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 2499), 8'($urandom));
      k = (cyc - 5) & 63;
      ka = (cyc - 3) & 63;
      checks++;
      if ({red, green, blue} !== e_rgb[k]) begin
        failures++; $display("FAIL rand_rgb cyc=%0d got=%h required=%h", cyc, {red, green, blue}, e_rgb[k]);
      end
      checks++;
      if ({HS, VS, VA} !== {e_hs[k], e_vs[k], e_va[k]}) begin
        failures++; $display("FAIL rand_sync cyc=%0d got=%b%b%b required=%b%b%b",
                             cyc, HS, VS, VA, e_hs[k], e_vs[k], e_va[k]);
      end
      if (e_rav[ka]) begin
        checks++;
        if (rom_addr !== e_ra[ka]) begin
          failures++; $display("FAIL rand_rom_addr cyc=%0d got=%h required=%h", cyc, rom_addr, e_ra[ka]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 6; i++) drive(9, 16, 1'b1, 1'b1, 1'b1, 1'b0, 0, 8'd0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({red, green, blue, HS, VS, VA} !== 27'd0 || rom_addr !== 11'd0) begin
      failures++;
      $display("FAIL reset_async got rgb=%h sync=%b%b%b rom_addr=%h, required all zero",
               {red, green, blue}, HS, VS, VA, rom_addr);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_ring();
    for (int i = 0; i < 16; i++) begin
      int k, ka;
      drive($urandom_range(0, 799), $urandom_range(0, 479), 1'($urandom), 1'($urandom),
            1'($urandom), 1'b0, 0, 8'd0);
      k = (cyc - 5) & 63;
      ka = (cyc - 3) & 63;
      checks++;
      if ({red, green, blue} !== e_rgb[k] || {HS, VS, VA} !== {e_hs[k], e_vs[k], e_va[k]}) begin
        failures++;
        $display("FAIL midframe_resume cyc=%0d got rgb=%h sync=%b%b%b required rgb=%h sync=%b%b%b",
                 cyc, {red, green, blue}, HS, VS, VA, e_rgb[k], e_hs[k], e_vs[k], e_va[k]);
      end
      if (e_rav[ka]) begin
        checks++;
        if (rom_addr !== e_ra[ka]) begin
          failures++; $display("FAIL midframe_rom_addr cyc=%0d got=%h required=%h", cyc, rom_addr, e_ra[ka]);
        end
      end
    end
  endtask

`ifdef CHAR_CURSOR_EN
  task automatic test_cursor();
    cursor_col = 7'd2;
    cursor_row = 5'd3;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clear_ring();
    for (int f = 0; f < 64; f++) begin
      int k;
      drive(16 + $urandom_range(0, 7), 62 + $urandom_range(0, 1), 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'd0);
      idle(); idle(); idle(); idle();
      k = (cyc - 5) & 63;
      checks++;
      if ({red, green, blue} !== e_rgb[k] || (f < 32 && {red, green, blue} !== FG)) begin
        failures++; $display("FAIL cursor frame=%0d got=%h required=%h", f, {red, green, blue}, e_rgb[k]);
      end
      drive(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'd0);
      idle();
    end
    cursor_row = 5'd31;
  endtask
`endif

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    rom[11'h410] = 8'h80;
    clear_ring();
    test_reset();
    fill_buffer();
    test_glyph_latency();
    test_inverse_bounds();
    test_blank_grid_edge();
    test_read_during_write();
    test_random();
    test_reset_midframe();
`ifdef CHAR_CURSOR_EN
    test_cursor();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/char_text_renderer.md
Name: char_text_renderer

Overview:
- Text-mode pixel generator between the VGA timing generator and the HDMI TMDS encoder.
- Holds an 80x30 character screen buffer and reads glyph rows from an external synchronous character ROM.
- Produces 24-bit RGB with HS/VS/VA delayed to match, so its outputs drive the encoder's red/green/blue/hsync/vsync/vde inputs directly.
- Runs entirely in the pixel clock domain.

Parameters:
- COLS, 80, character columns per row.
- ROWS, 30, character rows per screen.
- CHAR_W, 8, glyph width in pixels; fixed at 8.
- CHAR_H, 16, glyph height in pixels; fixed at 16.
- FG_COLOR, 24'hFFFFFF, foreground RGB as {r,g,b}.
- BG_COLOR, 24'h000000, background RGB used inside the active area.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-low reset
- hcount  in  11  horizontal pixel position from the timing generator
- vcount  in  10  vertical line position from the timing generator
- hs_in  in  1  horizontal sync, aligned with hcount
- vs_in  in  1  vertical sync, aligned with vcount
- va_in  in  1  video-active flag, aligned with hcount/vcount
- wr_en  in  1  screen-buffer write strobe
- wr_addr  in  12  buffer address = row*COLS + col
- wr_data  in  8  bit7 = inverse-video attribute; bits[6:0] = character code
- rom_addr  out  11  {code[6:0], glyph_row[3:0]}
- rom_data  in  8  glyph row, MSB = leftmost pixel; valid one clk after rom_addr
- red  out  8  pixel red
- green  out  8  pixel green
- blue  out  8  pixel blue
- HS  out  1  delayed hs_in
- VS  out  1  delayed vs_in
- VA  out  1  delayed va_in

Behaviour:
- Reset (rst=0, asynchronous): red/green/blue/HS/VS/VA/rom_addr and all pipeline registers clear to 0. Screen-buffer contents are not cleared.
- Screen buffer: COLS*ROWS x 8 synchronous RAM.
  - Write on a clk edge when wr_en=1 and wr_addr < COLS*ROWS.
  - Writes with wr_addr >= COLS*ROWS are ignored.
  - Read-during-write to the same address returns the old data.
- Pipeline: fixed 4-clock latency. Outputs after edge N+4 reflect inputs sampled at edge N.
  - Edge N: read address = (vcount>>4)*COLS + (hcount>>3).
  - Edge N+1: character byte available.
  - Edge N+2: rom_addr registered as {code[6:0], vcount[3:0]}.
  - Edge N+3: rom_data valid from the ROM.
  - Edge N+4: pixel registered.
  - hcount[2:0], attribute bit, va_in, hs_in and vs_in are delayed in lockstep with the data path.
- Pixel select: bit = rom_data[7 - hcount_d[2:0]]; if attribute=1, bit is inverted.
- Pixel colour:
  - va_d=0: RGB = 0 (blanking).
  - va_d=1 and position outside the COLS x ROWS grid (hcount>=COLS*8 or vcount>=ROWS*16): BG_COLOR.
  - Otherwise: FG_COLOR when bit=1, BG_COLOR when bit=0.
- HS/VS/VA: pure 4-cycle delays. Polarity is passed through unchanged.
- Reset mid-frame: outputs go to 0 immediately. After release, the first valid pixel appears 4 clocks after the first sampled input. No resynchronisation to frame start is required.

Optional Feature:
- Macro: CHAR_CURSOR_EN.
- Defined:
  - Adds inputs cursor_col (7 bits) and cursor_row (5 bits).
  - Adds a 6-bit frame counter. It increments on each rising edge of vs_in (detected by a registered compare) and resets to 0.
  - When counter[5]=0 and the pixel lies in cell (cursor_col, cursor_row) with glyph_row 14 or 15, the pixel is forced to FG_COLOR, giving an underline that blinks every 32 frames.
  - Latency is unchanged.
- Undefined: no cursor ports, no counter, behaviour exactly as above.

Test Plan:
- Reset: hold rst=0 with toggling timing inputs -> red/green/blue/HS/VS/VA/rom_addr all 0. Release -> outputs follow inputs 4 clocks later.
- Latency and glyph: write addr 0 = 8'h41; ROM model returns 8'h80 for row 0; drive hcount=0, vcount=0, va_in=1 at edge N -> rom_addr=11'h410 after N+2; RGB=24'hFFFFFF after N+4; hcount=1 gives 24'h000000.
- Inverse and bounds: write addr 81 = 8'hC1 -> cell (1,1) colours inverted. Write addr 2400 = 8'h55 -> no buffer location changes.
- Blanking and grid edge: va_in=0 -> RGB=0. va_in=1 with hcount=640 (outside the grid) -> BG_COLOR. hs_in pulse reappears on HS exactly 4 clocks later.
- Read-during-write: write 8'h42 to addr 5 while reading addr 5 -> old code on rom_addr; new code on the next access.
- CHAR_CURSOR_EN: cursor at (2,3); run 64 VS pulses -> underline rows 14–15 of that cell white for frames 0–31 and absent for frames 32–63.
